nonce_search_controller: RTL
============================

Name: nonce_search_controller

Overview:
- Drives the SHA computational block from downstream. It builds the 440-bit message as {header prefix, nonce} and pulses beginComputation, then waits for computationComplete.
- Compares the returned 256-bit digest against a target. It then either reports a winning nonce or increments the nonce and retries.
- Sits between the miner's host/register interface and the SHA computational block; it is the loop that turns one-shot hashing into a nonce search.

Parameters:
- MSG_W, 440, width of message sent to SHA block
- NONCE_W, 32, nonce width; occupies inputMsg[NONCE_W-1:0]
- HASH_W, 256, digest and target width
- WAIT_TIMEOUT, 1023, max cycles in WAIT before error; 0 disables

Ports:
- clk  in  1  system clock
- n_rst  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to begin a search; honoured in IDLE, FOUND, EXHAUSTED, ERROR
- abort  in  1  return to IDLE from any state
- headerPrefix  in  MSG_W-NONCE_W  fixed message bits, latched on accepted start
- nonceStart  in  NONCE_W  first nonce, latched on accepted start
- nonceEnd  in  NONCE_W  last nonce (inclusive), latched on accepted start
- target  in  HASH_W  success threshold, latched on accepted start
- inputMsg  out  MSG_W  to SHA block: {prefixReg, nonceReg}
- beginComputation  out  1  one-cycle start pulse to SHA block
- computationComplete  in  1  from SHA block
- SHAoutput  in  HASH_W  digest from SHA block
- busy  out  1  high in LOAD/START/WAIT/COMPARE
- found  out  1  level, high in FOUND
- exhausted  out  1  level, high in EXHAUSTED
- timeoutErr  out  1  level, high in ERROR
- goldenNonce  out  NONCE_W  winning nonce
- goldenHash  out  HASH_W  winning digest
- hashCount  out  NONCE_W  digests compared since last accepted start, saturating

Behaviour:
- Reset values: all outputs 0, state IDLE, internal regs 0.
- States: IDLE, LOAD, START, WAIT, COMPARE, FOUND, EXHAUSTED, ERROR.
- Accepted start: latch prefix, nonceStart, nonceEnd and target; set nonceReg=nonceStart; clear hashCount, found, exhausted, timeoutErr, goldenNonce and goldenHash; go to LOAD.
- LOAD: inputMsg becomes valid this cycle; go to START. This gives the SHA preprocessor one cycle of stable input before the pulse.
- START: beginComputation=1 for exactly this cycle; clear wait counter; go to WAIT.
- WAIT:
  - computationComplete=1 → capture SHAoutput into hashReg; go to COMPARE.
  - Otherwise the wait counter increments. When WAIT_TIMEOUT≠0 and the counter reaches WAIT_TIMEOUT → go to ERROR.
  - computationComplete outside WAIT is ignored.
- COMPARE:
  - Unsigned compare hashReg < targetReg, strict.
  - hashCount increments, saturating at all-ones.
  - If less → goldenNonce=nonceReg, goldenHash=hashReg, go to FOUND.
  - Else if nonceReg==nonceEnd → go to EXHAUSTED.
  - Else nonceReg+1 (modulo 2^NONCE_W) and go to LOAD.
- Wrap-around: nonceStart > nonceEnd is legal. The search wraps through all-ones to 0 and still stops at nonceEnd. nonceStart==nonceEnd tests exactly one nonce.
- FOUND/EXHAUSTED/ERROR hold their status level and golden regs until an accepted start or abort.
- inputMsg is stable from LOAD through WAIT. It changes only on LOAD entry via nonceReg update or start latch.
- Per-nonce latency: 3 cycles (LOAD, START, COMPARE) plus SHA latency.
- abort:
  - Has priority over all transitions, including simultaneous start and computationComplete.
  - Next state is IDLE; beginComputation forced 0.
  - found/exhausted/timeoutErr cleared; golden regs and hashCount retained.
- start while busy is ignored.
- Asynchronous reset mid-search returns everything to reset values immediately.

Decomposition:
- Shared package miner_pkg: typedef state enum; constants MSG_W, NONCE_W and HASH_W; SHA initial-hash constants if not already present.
- One sub-module, hash_target_compare: combinational HASH_W unsigned less-than, registered by the parent in COMPARE. Can be pipelined later without touching the FSM.

Test Plan:
- Target=all-ones, nonceStart=5, nonceEnd=9, SHA model returns 0 → found after first compare; goldenNonce=5; hashCount=1; exactly one beginComputation pulse.
- Target=0 (nothing can win), nonceStart=0xFFFFFFFE, nonceEnd=1 → nonces FFFFFFFE, FFFFFFFF, 0, 1 issued in order; exhausted=1; hashCount=4; inputMsg[31:0] matches each pulse.
- Model returns digest equal to target on nonce 3 and target-1 on nonce 4, range 3..10 → found with goldenNonce=4, confirming strict less-than.
- WAIT_TIMEOUT=8, model never asserts computationComplete → timeoutErr=1 exactly 9 cycles after the pulse cycle; busy=0.
- Abort asserted in WAIT coincident with computationComplete → IDLE next cycle; no COMPARE; hashCount unchanged; a following start relaunches cleanly.
- n_rst pulsed low mid-WAIT → all outputs 0 asynchronously; no beginComputation until a new start.

Source files
------------

// File: rtl/miner_pkg.sv
// miner_pkg
// Shared definitions for the miner datapath: message, nonce and digest
// widths plus the state encoding used by the nonce search controller.
package miner_pkg;

    localparam int MSG_W   = 440;
    localparam int NONCE_W = 32;
    localparam int HASH_W  = 256;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT,
        COMPARE,
        FOUND,
        EXHAUSTED,
        ERROR
    } searchState_t;

endpackage

// File: rtl/hash_target_compare.sv
// hash_target_compare
// Purely combinational unsigned strict less-than between a digest and the
// search target. The parent registers the result in its COMPARE state, so
// this block can later be pipelined without touching the controller FSM.
// Ports:
//   hashVal   - digest under test
//   targetVal - success threshold
//   isLess    - 1 when hashVal < targetVal (unsigned, strict)
module hash_target_compare #(
    parameter int HASH_W = miner_pkg::HASH_W
) (
    input  logic [HASH_W-1:0] hashVal,
    input  logic [HASH_W-1:0] targetVal,
    output logic              isLess
);

    assign isLess = (hashVal < targetVal);

endmodule

// File: rtl/nonce_search_controller.sv
// nonce_search_controller
// Loops the one-shot SHA block over a nonce range. For each nonce it
// presents {prefix, nonce}, pulses beginComputation, waits for the digest,
// and compares it with the target. Stops on a winning digest, on reaching
// the last nonce, or when the SHA block fails to answer in time.
// Ports:
//   clk, n_rst            - clock, asynchronous active-low reset
//   start, abort          - search request / unconditional return to IDLE
//   headerPrefix, nonceStart, nonceEnd, target - search job, latched on start
//   inputMsg, beginComputation                 - to the SHA block
//   computationComplete, SHAoutput             - from the SHA block
//   busy, found, exhausted, timeoutErr         - status levels
//   goldenNonce, goldenHash, hashCount         - results
module nonce_search_controller #(
    parameter int          MSG_W        = miner_pkg::MSG_W,
    parameter int          NONCE_W      = miner_pkg::NONCE_W,
    parameter int          HASH_W       = miner_pkg::HASH_W,
    parameter int unsigned WAIT_TIMEOUT = 1023
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     start,
    input  logic                     abort,
    input  logic [MSG_W-NONCE_W-1:0] headerPrefix,
    input  logic [NONCE_W-1:0]       nonceStart,
    input  logic [NONCE_W-1:0]       nonceEnd,
    input  logic [HASH_W-1:0]        target,
    output logic [MSG_W-1:0]         inputMsg,
    output logic                     beginComputation,
    input  logic                     computationComplete,
    input  logic [HASH_W-1:0]        SHAoutput,
    output logic                     busy,
    output logic                     found,
    output logic                     exhausted,
    output logic                     timeoutErr,
    output logic [NONCE_W-1:0]       goldenNonce,
    output logic [HASH_W-1:0]        goldenHash,
    output logic [NONCE_W-1:0]       hashCount
);

    import miner_pkg::*;

    // Counter is one value wider than the timeout so it never wraps before
    // the limit is hit; WAIT_TIMEOUT = 0 leaves it free-running and unused.
    localparam int                CNT_W        = $clog2(WAIT_TIMEOUT + 2);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(WAIT_TIMEOUT - 1);

    searchState_t               state;
    logic [MSG_W-NONCE_W-1:0]   prefixReg;
    logic [NONCE_W-1:0]         nonceReg;
    logic [NONCE_W-1:0]         nonceEndReg;
    logic [HASH_W-1:0]          targetReg;
    logic [HASH_W-1:0]          hashReg;
    logic [CNT_W-1:0]           waitCnt;
    logic                       hashLess;

    assign inputMsg = {prefixReg, nonceReg};

    hash_target_compare #(.HASH_W(HASH_W)) uCompare (
        .hashVal   (hashReg),
        .targetVal (targetReg),
        .isLess    (hashLess)
    );

    // Search FSM with all outputs registered. beginComputation is set on
    // the LOAD->START transition so it is high for exactly the START cycle.
    // abort outranks every other transition but keeps the golden results
    // and hashCount so the host can still read them afterwards.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state            <= IDLE;
            prefixReg        <= '0;
            nonceReg         <= '0;
            nonceEndReg      <= '0;
            targetReg        <= '0;
            hashReg          <= '0;
            waitCnt          <= '0;
            beginComputation <= 1'b0;
            busy             <= 1'b0;
            found            <= 1'b0;
            exhausted        <= 1'b0;
            timeoutErr       <= 1'b0;
            goldenNonce      <= '0;
            goldenHash       <= '0;
            hashCount        <= '0;
        end else if (abort) begin
            state            <= IDLE;
            beginComputation <= 1'b0;
            busy             <= 1'b0;
            found            <= 1'b0;
            exhausted        <= 1'b0;
            timeoutErr       <= 1'b0;
        end else begin
            beginComputation <= 1'b0;
            case (state)
                IDLE, FOUND, EXHAUSTED, ERROR: begin
                    if (start) begin
                        prefixReg   <= headerPrefix;
                        nonceReg    <= nonceStart;
                        nonceEndReg <= nonceEnd;
                        targetReg   <= target;
                        hashCount   <= '0;
                        found       <= 1'b0;
                        exhausted   <= 1'b0;
                        timeoutErr  <= 1'b0;
                        goldenNonce <= '0;
                        goldenHash  <= '0;
                        busy        <= 1'b1;
                        state       <= LOAD;
                    end
                end
                LOAD: begin
                    beginComputation <= 1'b1;
                    state            <= START;
                end
                START: begin
                    waitCnt <= '0;
                    state   <= WAIT;
                end
                WAIT: begin
                    if (computationComplete) begin
                        hashReg <= SHAoutput;
                        state   <= COMPARE;
                    end else begin
                        waitCnt <= waitCnt + 1'b1;
                        if ((WAIT_TIMEOUT != 0) && (waitCnt == TIMEOUT_LAST)) begin
                            timeoutErr <= 1'b1;
                            busy       <= 1'b0;
                            state      <= ERROR;
                        end
                    end
                end
                COMPARE: begin
                    if (hashCount != '1) begin
                        hashCount <= hashCount + 1'b1;
                    end
                    if (hashLess) begin
                        goldenNonce <= nonceReg;
                        goldenHash  <= hashReg;
                        found       <= 1'b1;
                        busy        <= 1'b0;
                        state       <= FOUND;
                    end else if (nonceReg == nonceEndReg) begin
                        exhausted <= 1'b1;
                        busy      <= 1'b0;
                        state     <= EXHAUSTED;
                    end else begin
                        // Plain modulo increment lets a range wrap through
                        // all-ones back to zero.
                        nonceReg <= nonceReg + 1'b1;
                        state    <= LOAD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
